// File: rtl/gshare_predictor_pkg.sv
// Shared types and helpers for the gshare direction predictor.
// Counter helpers work on 4-bit values so any counter width from 2 to 4 fits.
package bp_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int unsigned CTR_MAX_W = 4;

  // Weak not-taken: the value just below the counter midpoint.
  function automatic logic [CTR_MAX_W-1:0] ctr_init(input int unsigned w);
    return CTR_MAX_W'((1 << (w - 1)) - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] c,
                                                   input int unsigned w);
    logic [CTR_MAX_W-1:0] mx;
    mx = CTR_MAX_W'((1 << w) - 1);
    return (c >= mx) ? mx : c + 1'b1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] c,
                                                   input int unsigned w);
    if (w == 0) return '0;
    return (c == '0) ? '0 : c - 1'b1;
  endfunction

  // Word-aligned PC bits, optionally XORed with the zero-extended history.
  function automatic logic [31:0] bp_hash(input logic [31:0] pc,
                                          input logic [31:0] ghr,
                                          input int unsigned idx_w,
                                          input bit          use_global);
    logic [31:0] mask;
    logic [31:0] base;
    mask = (32'd1 << idx_w) - 32'd1;
    base = (pc >> 2) & mask;
    return use_global ? ((base ^ ghr) & mask) : base;
  endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-query and EX-update signal bundle for the gshare predictor.
interface gshare_predictor_if #(
  parameter int unsigned GHR_W = 8
);
  logic             query_valid;
  logic [31:0]      pc;
  logic             predict_taken;
  logic [GHR_W-1:0] ghr_snap;
  logic             ready;
  logic             update_en;
  logic [31:0]      pc_u;
  logic [GHR_W-1:0] ghr_u;
  logic             branch_taken;
  logic             mispredict;
  logic [31:0]      perf_updates;
  logic [31:0]      perf_mispredicts;

  modport master (
    output query_valid, pc, update_en, pc_u, ghr_u, branch_taken, mispredict,
    input  predict_taken, ghr_snap, ready, perf_updates, perf_mispredicts
  );

  modport slave (
    input  query_valid, pc, update_en, pc_u, ghr_u, branch_taken, mispredict,
    output predict_taken, ghr_snap, ready, perf_updates, perf_mispredicts
  );
endinterface

// File: rtl/gshare_table.sv
// Saturating-counter storage: two combinational read ports, one write port,
// and the post-reset sweep that overrides normal writes.
module gshare_table #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             init_en,
  input  logic [IDX_W-1:0] init_ptr,
  input  logic [CTR_W-1:0] init_val,
  input  logic [IDX_W-1:0] rd_idx_q,
  output logic [CTR_W-1:0] rd_data_q,
  input  logic [IDX_W-1:0] rd_idx_u,
  output logic [CTR_W-1:0] rd_data_u,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [CTR_W-1:0] wr_data
);
  localparam int unsigned DEPTH = 1 << IDX_W;

  (* ram_style = "distributed" *) logic [CTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (init_en)
      mem[init_ptr] <= init_val;
    else if (wr_en)
      mem[wr_idx] <= wr_data;
  end

  assign rd_data_q = mem[rd_idx_q];
  assign rd_data_u = mem[rd_idx_u];
endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: init sweep FSM, speculative GHR with
// mispredict repair, counter update path and performance counters.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned CTR_W      = 2,
  parameter int unsigned GHR_W      = 8,
  parameter int unsigned USE_GLOBAL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  gshare_predictor_if.slave     bus
);
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  state_t           state, state_next;
  logic [IDX_W-1:0] init_ptr;
  logic [GHR_W-1:0] ghr, ghr_next;
  logic [31:0]      perf_upd, perf_misp;
  logic             running;
  logic [IDX_W-1:0] idx_q, idx_u;
  logic [CTR_W-1:0] ctr_q, ctr_u, ctr_new;

  assign running = (state == RUN);

  assign idx_q = IDX_W'(bp_hash(bus.pc,   32'(ghr),       IDX_W, USE_GLOBAL != 0));
  assign idx_u = IDX_W'(bp_hash(bus.pc_u, 32'(bus.ghr_u), IDX_W, USE_GLOBAL != 0));

  assign ctr_new = bus.branch_taken ? CTR_W'(sat_inc(CTR_MAX_W'(ctr_u), CTR_W))
                                    : CTR_W'(sat_dec(CTR_MAX_W'(ctr_u), CTR_W));

  gshare_table #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_table (
    .clk       (clk),
    .init_en   (!running),
    .init_ptr  (init_ptr),
    .init_val  (CTR_INIT),
    .rd_idx_q  (idx_q),
    .rd_data_q (ctr_q),
    .rd_idx_u  (idx_u),
    .rd_data_u (ctr_u),
    .wr_en     (running && bus.update_en),
    .wr_idx    (idx_u),
    .wr_data   (ctr_new)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT)
        init_ptr <= init_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      INIT:    if (&init_ptr) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  assign bus.predict_taken = running && ctr_q[CTR_W-1];

  // The width casts keep the low GHR_W bits, which also covers GHR_W == 1.
  always_comb begin
    ghr_next = ghr;
    if (running) begin
      if (bus.update_en && bus.mispredict)
        ghr_next = GHR_W'({bus.ghr_u, bus.branch_taken});
      else if (bus.query_valid)
        ghr_next = GHR_W'({ghr, bus.predict_taken});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr       <= '0;
      perf_upd  <= '0;
      perf_misp <= '0;
    end else begin
      ghr <= ghr_next;
      if (running && bus.update_en) begin
        perf_upd <= perf_upd + 32'd1;
        if (bus.mispredict)
          perf_misp <= perf_misp + 32'd1;
      end
    end
  end

  assign bus.ready            = running;
  assign bus.ghr_snap         = ghr;
  assign bus.perf_updates     = perf_upd;
  assign bus.perf_mispredicts = perf_misp;
endmodule
